seg_scan_driver: RTL and testbench

- Downstream consumer of the BCD converter's digit pairs. It drives a 4-digit, common-anode, multiplexed seven-segment display with two BCD pairs, for example PC and an ALU result.
- Digits are latched into a shadow register on a load strobe. They are committed to the display only at a scan-frame boundary, so the display never tears.
- The block includes a refresh prescaler, a digit scan counter, segment decode, and optional leading-zero blanking.

---
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus bundle for the seven-segment scan driver.
// The display-side producer drives the digits; the driver returns the anode and segment lines.
interface seg_scan_driver_if;
  logic       load;
  logic [3:0] d1_lo;
  logic [3:0] d10_lo;
  logic [3:0] d1_hi;
  logic [3:0] d10_hi;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;
  logic       pending;

  modport master (
    output load, d1_lo, d10_lo, d1_hi, d10_hi, blank_lz,
    input  an, seg, frame_done, pending
  );

  modport slave (
    input  load, d1_lo, d10_lo, d1_hi, d10_hi, blank_lz,
    output an, seg, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver (common anode).
// Shadowed digit load, commit at frame wrap, leading-zero blanking.
module seg_scan_driver #(
  parameter int PRESCALE     = 50000,
  parameter bit DASH_INVALID = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;
  logic          boundary;
  logic [15:0]   din;
  logic [15:0]   shadow;
  logic [15:0]   active;
  logic          pend;
  logic          fdone;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [3:0]    dig;
  logic          blank;
  logic          z3;
  logic          z2;
  logic          z1;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;

  assign din      = {bus.d10_hi, bus.d1_hi, bus.d10_lo, bus.d1_lo};
  assign tick     = (cnt == LAST);
  assign boundary = tick && (idx == 2'd3);

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = DASH_INVALID ? 7'b0111111 : 7'b1111111;
    endcase
    return s;
  endfunction

  // Refresh prescaler: one tick per digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit scan index, advances once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Shadow capture and tear-free commit at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pend   <= 1'b0;
      fdone  <= 1'b0;
    end else begin
      fdone <= boundary;
      if (bus.load) begin
        shadow <= din;
      end
      if (boundary) begin
        pend <= 1'b0;
        if (bus.load) begin
          active <= din;
        end else if (pend) begin
          active <= shadow;
        end
      end else if (bus.load) begin
        pend <= 1'b1;
      end
    end
  end

  // Digit select and leading-zero blanking for the current slot
  always_comb begin
    z3    = (active[15:12] == 4'd0);
    z2    = (active[11:8] == 4'd0);
    z1    = (active[7:4] == 4'd0);
    dig   = active[3:0];
    blank = 1'b0;
    unique case (idx)
      2'd0: begin
        dig   = active[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        dig   = active[7:4];
        blank = z3 & z2 & z1;
      end
      2'd2: begin
        dig   = active[11:8];
        blank = z3 & z2;
      end
      2'd3: begin
        dig   = active[15:12];
        blank = z3;
      end
    endcase
    an_d  = ~(4'b0001 << idx);
    seg_d = (bus.blank_lz && blank) ? 7'b1111111 : decode(dig);
  end

  // Registered anode and segment drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fdone;
  assign bus.pending    = pend;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at PRESCALE=4.
// Each task drives its scenario and checks against hand-computed patterns.
module tb_seg_scan_driver;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'b1111111;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [3:0] cap_an [4];
  logic [6:0] cap_seg[4];
  logic [6:0] exp_seg[4];

  seg_scan_driver_if bus();

  seg_scan_driver #(
    .PRESCALE    (4),
    .DASH_INVALID(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] h10, input logic [3:0] h1,
                       input logic [3:0] l10, input logic [3:0] l1);
    bus.d10_hi = h10;
    bus.d1_hi  = h1;
    bus.d10_lo = l10;
    bus.d1_lo  = l1;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cap_an[i]  = bus.an;
      cap_seg[i] = bus.seg;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name);
    logic [3:0] ea;
    for (int i = 0; i < 4; i++) begin
      ea    = 4'b1111;
      ea[i] = 1'b0;
      tests++;
      if (cap_an[i] !== ea || cap_seg[i] !== exp_seg[i]) begin
        fails++;
        $display("FAIL %s digit%0d: got an=%b seg=%b expected an=%b seg=%b",
                 name, i, cap_an[i], cap_seg[i], ea, exp_seg[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    bit         fd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.an !== 4'b1111 || bus.seg !== BLK || bus.frame_done !== 1'b0
        || bus.pending !== 1'b0) begin
      fails++;
      $display("FAIL reset: got an=%b seg=%b fd=%b pend=%b expected 1111 1111111 0 0",
               bus.an, bus.seg, bus.frame_done, bus.pending);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      ea = 4'b1111;
      ea[((k - 1) / 4) % 4] = 1'b0;
      fd = (k % 16) == 0;
      tests++;
      if (bus.an !== ea || bus.frame_done !== fd || bus.seg !== S0) begin
        fails++;
        $display("FAIL scan k=%0d: got an=%b fd=%b seg=%b expected an=%b fd=%b seg=%b",
                 k, bus.an, bus.frame_done, bus.seg, ea, fd, S0);
      end
    end
  endtask

  task automatic test_load_commit();
    bit ok;
    bit seen;
    wait_frame(ok);
    repeat (5) @(negedge clk);
    drive(4'd4, 4'd2, 4'd9, 4'd7);
    tests++;
    if (bus.pending !== 1'b1) begin
      fails++;
      $display("FAIL commit_pend: got %b expected 1", bus.pending);
    end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tests++;
      if (bus.pending !== 1'b1 || bus.seg !== S0) begin
        fails++;
        $display("FAIL commit_hold: got pend=%b seg=%b expected 1 %b",
                 bus.pending, bus.seg, S0);
      end
    end
    tests++;
    if (!seen || bus.pending !== 1'b0) begin
      fails++;
      $display("FAIL commit_boundary: got seen=%b pend=%b expected 1 0", seen, bus.pending);
    end
    capture();
    exp_seg = '{S7, S9, S2, S4};
    check_frame("commit");
  endtask

  task automatic test_back_to_back();
    bit ok;
    repeat (2) @(negedge clk);
    drive(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    drive(4'd5, 4'd6, 4'd7, 4'd8);
    tests++;
    if (bus.pending !== 1'b1) begin
      fails++;
      $display("FAIL b2b_pend: got %b expected 1", bus.pending);
    end
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_wait: got timeout expected frame_done");
    end
    exp_seg = '{S8, S7, S6, S5};
    capture();
    check_frame("b2b_frame1");
    capture();
    check_frame("b2b_frame2");
  endtask

  task automatic test_load_on_boundary();
    repeat (15) @(negedge clk);
    drive(4'd3, 4'd0, 4'd5, 4'd9);
    tests++;
    if (bus.frame_done !== 1'b1 || bus.pending !== 1'b0) begin
      fails++;
      $display("FAIL boundary_load: got fd=%b pend=%b expected 1 0",
               bus.frame_done, bus.pending);
    end
    capture();
    exp_seg = '{S9, S5, S0, S3};
    check_frame("boundary_frame");
    tests++;
    if (bus.pending !== 1'b0) begin
      fails++;
      $display("FAIL boundary_pend: got %b expected 0", bus.pending);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    bus.blank_lz = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 4'd5);
    wait_frame(ok);
    capture();
    exp_seg = '{S5, BLK, BLK, BLK};
    check_frame("lz_0005");
    drive(4'd0, 4'd0, 4'd0, 4'd0);
    wait_frame(ok);
    capture();
    exp_seg = '{S0, BLK, BLK, BLK};
    check_frame("lz_0000");
    bus.blank_lz = 1'b0;
    capture();
    exp_seg = '{S0, S0, S0, S0};
    check_frame("nolz_0000");
    bus.blank_lz = 1'b1;
    drive(4'd0, 4'd12, 4'd0, 4'd3);
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL lz_wait: got timeout expected frame_done");
    end
    capture();
    exp_seg = '{S3, S0, DASH, BLK};
    check_frame("lz_dash");
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    drive(4'd9, 4'd9, 4'd9, 4'd9);
    tests++;
    if (bus.pending !== 1'b1) begin
      fails++;
      $display("FAIL areset_pend_before: got %b expected 1", bus.pending);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.an !== 4'b1111 || bus.seg !== BLK || bus.pending !== 1'b0
        || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL areset_now: got an=%b seg=%b pend=%b fd=%b expected 1111 1111111 0 0",
               bus.an, bus.seg, bus.pending, bus.frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame(ok);
    tests++;
    if (!ok || bus.pending !== 1'b0) begin
      fails++;
      $display("FAIL areset_after: got ok=%b pend=%b expected 1 0", ok, bus.pending);
    end
    capture();
    exp_seg = '{S0, S0, S0, S0};
    check_frame("areset_frame");
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.d1_lo    = 4'd0;
    bus.d10_lo   = 4'd0;
    bus.d1_hi    = 4'd0;
    bus.d10_hi   = 4'd0;
    bus.blank_lz = 1'b0;
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_load_on_boundary();
    test_blanking();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
